// File: rtl/riscv_v_skid_stage.sv
// Purpose: elastic valid/ready stage with 2-entry skid buffer feeding the vector stage chain.
// Latency: 1 cycle from accept to out_data; sustains 1 beat/cycle while out_ready=1.
// Backpressure: in_ready is registered state only (drops when FULL), no path from out_ready.
module riscv_v_skid_stage #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_accept;
    logic              w_send;
    logic              w_main_ld;
    logic              w_main_from_skid;
    logic              w_skid_ld;
    logic [1:0]        w_drop_inc;
    logic [CNT_W:0]    w_drop_sum;
    logic [CNT_W-1:0]  w_drop_nxt;

    // Outputs are gated by rst_n so they read idle throughout the synchronous reset window.
    assign in_ready  = rst_n & (r_state != ST_FULL);
    assign out_valid = rst_n & (r_state != ST_EMPTY);
    assign out_data  = r_main;
    assign occupancy = rst_n ? r_state : 2'd0;
    assign drop_cnt  = r_drop_cnt;

    assign w_accept = in_valid & in_ready;
    assign w_send   = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_main_ld   = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_send) begin
                    w_main_ld = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_skid_ld   = 1'b1;
                end else if (w_send) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_send) begin
                    w_state_nxt      = ST_ONE;
                    w_main_ld        = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // A beat sent during flush belongs downstream; everything else held or arriving is lost.
    assign w_drop_inc = r_state - {1'b0, w_send} + {1'b0, w_accept};
    assign w_drop_sum = {1'b0, r_drop_cnt} + {{(CNT_W-1){1'b0}}, w_drop_inc};
    assign w_drop_nxt = w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_state    <= ST_EMPTY;
            r_drop_cnt <= w_drop_nxt;
        end else begin
            r_state <= w_state_nxt;
            if (w_main_ld) begin
                r_main <= w_main_from_skid ? r_skid : in_data;
            end
            if (w_skid_ld) begin
                r_skid <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_riscv_v_skid_stage.sv
// Directed bench for riscv_v_skid_stage: driver pushes expected beats into a queue,
// an independent monitor pops and compares on every downstream handshake.
module tb_riscv_v_skid_stage;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  drop_cnt;

    logic [DATA_W-1:0] exp_q[$];
    int                total;
    int                bad;
    logic [15:0]       rdy_pat;

    riscv_v_skid_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got 0x%0h with empty scoreboard", out_data);
            end else begin
                check("out_data_order", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rdy_pat   = 16'b1011_0010_1110_0101;

        // 1: reset, then release
        tick();
        check("rst_out_valid", {31'h0, out_valid}, 32'd0);
        check("rst_in_ready", {31'h0, in_ready}, 32'd0);
        tick();
        tick();
        check("rst_drop_cnt", {24'h0, drop_cnt}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_out_valid", {31'h0, out_valid}, 32'd0);
        check("idle_in_ready", {31'h0, in_ready}, 32'd1);
        check("idle_occ", {30'h0, occupancy}, 32'd0);

        // 2: back-to-back stream at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            check("stream_in_ready", {31'h0, in_ready}, 32'd1);
            exp_q.push_back(DATA_W'(i));
            tick();
            check("stream_latency", {16'h0, out_data}, i);
            check("stream_occ", {30'h0, occupancy}, 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained_occ", {30'h0, occupancy}, 32'd0);

        // 3: fill the skid under backpressure, then release
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hAAAA;
        exp_q.push_back(16'hAAAA);
        tick();
        in_data = 16'h5555;
        exp_q.push_back(16'h5555);
        tick();
        in_valid = 1'b0;
        check("full_occ", {30'h0, occupancy}, 32'd2);
        check("full_in_ready", {31'h0, in_ready}, 32'd0);
        check("full_out_data", {16'h0, out_data}, 32'h0000_AAAA);
        tick();
        check("full_hold_data", {16'h0, out_data}, 32'h0000_AAAA);
        check("full_hold_occ", {30'h0, occupancy}, 32'd2);
        out_ready = 1'b1;
        tick();
        check("skid_in_ready", {31'h0, in_ready}, 32'd1);
        check("skid_out_data", {16'h0, out_data}, 32'h0000_5555);
        check("skid_occ", {30'h0, occupancy}, 32'd1);
        tick();
        check("skid_drained_occ", {30'h0, occupancy}, 32'd0);

        // 4: flush a full stage with no traffic
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1111;
        tick();
        in_data = 16'h2222;
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_full_occ", {30'h0, occupancy}, 32'd0);
        check("flush_full_valid", {31'h0, out_valid}, 32'd0);
        check("flush_full_drop", {24'h0, drop_cnt}, 32'd2);

        // 5: flush in ONE with send and accept both active
        in_valid = 1'b1;
        in_data  = 16'h3333;
        exp_q.push_back(16'h3333);
        tick();
        in_data   = 16'h4444;
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_send_q_empty", exp_q.size(), 32'd0);
        check("flush_send_occ", {30'h0, occupancy}, 32'd0);
        check("flush_send_drop", {24'h0, drop_cnt}, 32'd3);

        // Mixed backpressure stream with handshake-aware driver
        for (int i = 0; i < 12; i++) begin
            int guard;
            guard    = 0;
            in_valid = 1'b1;
            in_data  = 16'h0010 + DATA_W'(i);
            while (!in_ready && guard < 50) begin
                out_ready = rdy_pat[(i + guard) % 16];
                tick();
                guard++;
            end
            if (!in_ready) begin
                check("mix_in_ready_timeout", {31'h0, in_ready}, 32'd1);
            end
            exp_q.push_back(16'h0010 + DATA_W'(i));
            out_ready = rdy_pat[i % 16];
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int g = 0; g < 20 && exp_q.size() != 0; g++) tick();
        check("mix_drain_q_empty", exp_q.size(), 32'd0);
        check("mix_drain_drop", {24'h0, drop_cnt}, 32'd3);

        // 6: saturate the drop counter, then clear by reset
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        flush     = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 9) check("sat_ramp_drop", {24'h0, drop_cnt}, 32'd13);
            if (i == 251) check("sat_reach_drop", {24'h0, drop_cnt}, 32'd255);
        end
        check("sat_hold_drop", {24'h0, drop_cnt}, 32'd255);
        check("sat_occ", {30'h0, occupancy}, 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("rerst_drop", {24'h0, drop_cnt}, 32'd0);
        check("rerst_in_ready", {31'h0, in_ready}, 32'd0);
        check("rerst_occ", {30'h0, occupancy}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("final_q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
